// File: rtl/regfile32x8_pkg.sv
// Shared CPU constants and the write-enable classification used by the register file.
package cpu_pkg;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 8;

    localparam logic [DW-1:0] REG_RST = '0;

    typedef enum logic [1:0] {
        WR_NONE,
        WR_ONE,
        WR_MULTI
    } wr_class_e;

endpackage

// File: rtl/regfile32x8_onehot_chk.sv
// Classifies a 32-bit enable vector as none / exactly-one / multi-hot using
// a pairwise OR/AND reduction tree.
module onehot_chk (
    input  logic [31:0] we,
    output logic        none,
    output logic        one,
    output logic        multi
);

    logic [31:0] any_v;
    logic [31:0] mul_v;
    logic [31:0] nany;
    logic [31:0] nmul;

    // Each tree node carries (any bit set, two or more bits set) for its subtree.
    always_comb begin
        any_v = we;
        mul_v = '0;
        nany  = '0;
        nmul  = '0;
        for (int unsigned lvl = 0; lvl < 5; lvl++) begin
            nany = '0;
            nmul = '0;
            for (int unsigned k = 0; k < 16; k++) begin
                nany[k] = any_v[2*k] | any_v[2*k+1];
                nmul[k] = mul_v[2*k] | mul_v[2*k+1] | (any_v[2*k] & any_v[2*k+1]);
            end
            any_v = nany;
            mul_v = nmul;
        end
    end

    assign none  = ~any_v[0];
    assign multi = mul_v[0];
    assign one   = any_v[0] & ~mul_v[0];

endmodule

// File: rtl/regfile32x8.sv
// 32-entry register file with one-hot write enables, two combinational read
// ports, a sticky multi-hot fault flag and a written-since-reset bitmap.
module regfile32x8 #(
    parameter int unsigned DW = cpu_pkg::DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [31:0]   WE,
    input  logic [DW-1:0] D,
    input  logic [4:0]    RA,
    input  logic [4:0]    RB,
    output logic [DW-1:0] QA,
    output logic [DW-1:0] QB,
    output logic          ERR,
    output logic [31:0]   WR
);

    import cpu_pkg::*;

    logic [DW-1:0] regs [NREG];
    logic          we_none;
    logic          we_one;
    logic          we_multi;
    wr_class_e     wr_class;

    onehot_chk u_onehot_chk (
        .we    (WE),
        .none  (we_none),
        .one   (we_one),
        .multi (we_multi)
    );

    always_comb begin
        wr_class = WR_NONE;
        if (we_multi)
            wr_class = WR_MULTI;
        else if (we_one && !we_none)
            wr_class = WR_ONE;
    end

    // Entry 0 is only ever loaded by reset, so it reads zero without a mux special case.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < NREG; i++)
                regs[i] <= DW'(REG_RST);
            WR  <= '0;
            ERR <= 1'b0;
        end else begin
            case (wr_class)
                WR_ONE: begin
                    for (int unsigned i = 1; i < NREG; i++)
                        if (WE[i])
                            regs[i] <= D;
                    WR <= WR | {WE[31:1], 1'b0};
                end
                WR_MULTI: ERR <= 1'b1;
                default: ;
            endcase
        end
    end

    assign QA = regs[RA];
    assign QB = regs[RB];

endmodule
